// File: rtl/ysyx_24100029_ifid_queue.sv
// Fetch-to-decode instruction buffer: in-order {pc, inst} circular queue with
// flush and a saturating decode-starvation counter.
module ysyx_24100029_ifid_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         starve_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned ENT_W = 2 * XLEN;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rp;
    logic [PTR_W-1:0] wp;
    logic             push_c;
    logic             pop_c;
    logic             starve_c;

    // Handshake flags are decoded from registered occupancy only.
    assign in_ready  = (count != OCC_W'(DEPTH));
    assign out_valid = (count != OCC_W'(0));
    assign push_c    = in_valid & in_ready & ~flush;
    assign pop_c     = out_valid & out_ready & ~flush;
    assign starve_c  = out_ready & ~out_valid & ~flush & ~(&starve_cnt);

    assign out_pc   = mem[rp][ENT_W-1:XLEN];
    assign out_inst = mem[rp][XLEN-1:0];

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wp] <= {in_pc, in_inst};
        end
    end

    // Pointers and occupancy; flush overrides any handshake in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else if (flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push_c) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop_c) begin
                rp <= rp + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of cycles decode wanted an instruction but had none.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (starve_c) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_ifid_queue.sv
// Bench for the fetch/decode queue: queue-based reference model checked by a
// negedge monitor, driven by directed scenarios followed by random traffic.
module tb_ysyx_24100029_ifid_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_inst;
    logic             flush;
    logic [OCC_W-1:0] count;
    logic [CNT_W-1:0] starve_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [2*XLEN-1:0] model_q[$];
    int unsigned       starve_m = 0;
    localparam int unsigned STARVE_MAX = (1 << CNT_W) - 1;

    ysyx_24100029_ifid_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .flush      (flush),
        .count      (count),
        .starve_cnt (starve_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance the model by this cycle's inputs.
    always @(negedge clock) begin
        if (!reset) begin
            model_q.delete();
            starve_m = 0;
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_pc", 64'(out_pc), 64'(0));
            chk("rst_out_inst", 64'(out_inst), 64'(0));
            chk("rst_starve", 64'(starve_cnt), 64'(0));
        end else begin
            automatic bit exp_valid = (model_q.size() != 0);
            automatic bit exp_ready = (model_q.size() != DEPTH);
            chk("count", 64'(count), 64'(model_q.size()));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("starve_cnt", 64'(starve_cnt), 64'(starve_m));
            if (exp_valid) begin
                chk("out_pc", 64'(out_pc), 64'(model_q[0][2*XLEN-1:XLEN]));
                chk("out_inst", 64'(out_inst), 64'(model_q[0][XLEN-1:0]));
            end
            if (out_ready && !exp_valid && !flush && starve_m != STARVE_MAX) begin
                starve_m++;
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_ready && exp_valid) void'(model_q.pop_front());
                if (in_valid && exp_ready) model_q.push_back({in_pc, in_inst});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                         input bit ordy, input bit fl);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Idle after reset: five starving cycles.
        repeat (5) step();
        chk("idle_starve", 64'(starve_cnt), 64'(5));
        chk("idle_count", 64'(count), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        // Fill and stall.
        drive(1'b1, 32'h2000_0000, 32'h0000_0413, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2000_0004, 32'h0010_0513, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2000_0008, 32'h0020_0593, 1'b0, 1'b0);
        chk("fill_count", 64'(count), 64'(2));
        chk("fill_in_ready", 64'(in_ready), 64'(0));
        chk("fill_head", 64'(out_pc), 64'(32'h2000_0000));
        step();
        chk("stall_head", 64'(out_pc), 64'(32'h2000_0000));
        chk("stall_count", 64'(count), 64'(2));

        // Full plus pop: the push waits one cycle.
        drive(1'b1, 32'h2000_0008, 32'h0020_0593, 1'b1, 1'b0); step();
        chk("fullpop_count", 64'(count), 64'(1));
        chk("fullpop_head", 64'(out_pc), 64'(32'h2000_0004));
        step();
        chk("fullpop_push_count", 64'(count), 64'(1));
        chk("fullpop_push_head", 64'(out_pc), 64'(32'h2000_0008));

        // Streaming.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h2000_000c + 32'(4 * i), 32'h0000_0013 + 32'(i), 1'b1, 1'b0);
            step();
            chk("stream_count", 64'(count), 64'(1));
            chk("stream_head", 64'(out_pc), 64'(32'h2000_000c + 32'(4 * i)));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0); step();

        // Flush with simultaneous push and pop.
        drive(1'b1, 32'h2000_0040, 32'h1111_1111, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2000_0044, 32'h2222_2222, 1'b0, 1'b0); step();
        chk("preflush_count", 64'(count), 64'(2));
        drive(1'b1, 32'hdead_beef, 32'h3333_3333, 1'b1, 1'b1); step();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        drive(1'b1, 32'h2000_0100, 32'h4444_4444, 1'b0, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("postflush_head", 64'(out_pc), 64'(32'h2000_0100));
        chk("postflush_count", 64'(count), 64'(1));

        // Drain and starve until saturation.
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (20) step();
        chk("starve_sat", 64'(starve_cnt), 64'(STARVE_MAX));

        // Asynchronous reset mid-stream.
        drive(1'b1, 32'h2000_0200, 32'h5555_5555, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2000_0204, 32'h6666_6666, 1'b0, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("prereset_count", 64'(count), 64'(2));
        #2 reset = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'(0));
        chk("areset_out_valid", 64'(out_valid), 64'(0));
        chk("areset_starve", 64'(starve_cnt), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 32'($urandom), 32'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
